// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use and long-latency op hazard detection for the
// decode/execute boundary, with a countdown scoreboard for one MUL/DIV in flight.
module fwd_hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int AW       = 5,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  idex_rs,
  input  logic [NUM_SRC-1:0]     idex_src_used,
  input  logic [NUM_SRC*AW-1:0]  ifid_rs,
  input  logic [NUM_SRC-1:0]     ifid_src_used,
  input  logic [AW-1:0]          idex_rd,
  input  logic                   idex_memread,
  input  logic                   lop_issue,
  input  logic [AW-1:0]          lop_issue_rd,
  input  logic [AW-1:0]          exmem_rd,
  input  logic                   exmem_regwrite,
  input  logic [AW-1:0]          memwb_rd,
  input  logic                   memwb_regwrite,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   lop_busy,
  output logic [AW-1:0]          lop_rd,
  output logic                   lop_complete,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int CW = $clog2(LONG_LAT) + 1;

  logic [CW-1:0] count;
  logic          load_use;
  logic          lop_hazard;
  logic          struct_hazard;
  logic          issue_ok;

  // EX/MEM is the younger producer, so it wins over MEM/WB
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idex_src_used[i] && exmem_regwrite && (exmem_rd != '0) &&
          (exmem_rd == idex_rs[i*AW +: AW]))
        fwd_sel[2*i +: 2] = 2'b10;
      else if (idex_src_used[i] && memwb_regwrite && (memwb_rd != '0) &&
               (memwb_rd == idex_rs[i*AW +: AW]))
        fwd_sel[2*i +: 2] = 2'b01;
    end
  end

  assign lop_complete = lop_busy && (count == CW'(1));

  always_comb begin
    load_use   = 1'b0;
    lop_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idex_memread && (idex_rd != '0) && ifid_src_used[i] &&
          (ifid_rs[i*AW +: AW] == idex_rd))
        load_use = 1'b1;
      // result is forwardable in its completion cycle, so no stall then
      if (lop_busy && !lop_complete && (lop_rd != '0) && ifid_src_used[i] &&
          (ifid_rs[i*AW +: AW] == lop_rd))
        lop_hazard = 1'b1;
    end
  end

  assign struct_hazard = lop_busy && lop_issue && !lop_complete;
  assign stall         = load_use || lop_hazard || struct_hazard;
  assign issue_ok      = lop_issue && (!lop_busy || lop_complete);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lop_busy <= 1'b0;
      lop_rd   <= '0;
      count    <= '0;
    end else if (issue_ok) begin
      lop_busy <= 1'b1;
      lop_rd   <= lop_issue_rd;
      count    <= CW'(LONG_LAT - 1);
    end else if (lop_complete) begin
      lop_busy <= 1'b0;
      count    <= '0;
    end else if (lop_busy && (count > CW'(1))) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
